// File: rtl/vital_alarm_controller_pkg.sv
// rtl/vital_alarm_controller_pkg.sv - shared types and constants for the vital-sign alarm stage
package vital_alarm_controller_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALARM   = 2'd2,
        ST_RECOVER = 2'd3
    } alarm_state_t;

    localparam int CNT_W             = 8;
    localparam int DEF_TRIP_COUNT    = 4;
    localparam int DEF_CLEAR_COUNT   = 8;

    function automatic logic is_one_hot3(input logic a, input logic b, input logic c);
        return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
    endfunction

endpackage

// File: rtl/vital_alarm_controller.sv
// rtl/vital_alarm_controller.sv - persistence-filtered alarm FSM fed by low/high limit comparators
module vital_alarm_controller
    import vital_alarm_controller_pkg::*;
#(
    parameter int TRIP_COUNT  = DEF_TRIP_COUNT,
    parameter int CLEAR_COUNT = DEF_CLEAR_COUNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sampleValid,
    input  logic             lowLess,
    input  logic             lowEqual,
    input  logic             lowGreater,
    input  logic             highLess,
    input  logic             highEqual,
    input  logic             highGreater,
    input  logic             ackPulse,
    output logic             alarm,
    output logic             pending,
    output logic             causeLow,
    output logic             causeHigh,
    output logic [CNT_W-1:0] tripCount,
    output logic             errFlag
);

    localparam logic [CNT_W-1:0] TRIP_N  = CNT_W'(TRIP_COUNT);
    localparam logic [CNT_W-1:0] CLEAR_N = CNT_W'(CLEAR_COUNT);

    alarm_state_t     state;
    logic [CNT_W-1:0] run;

    logic             flags_ok;
    logic             sample_ok;
    logic             malformed;
    logic             out_of_range;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] trip_inc;

    always_comb begin
        flags_ok     = is_one_hot3(lowLess, lowEqual, lowGreater)
                     && is_one_hot3(highLess, highEqual, highGreater);
        sample_ok    = sampleValid && flags_ok;
        malformed    = sampleValid && !flags_ok;
        // Touching a limit exactly is still considered in range.
        out_of_range = lowLess || highGreater;
        run_inc      = run + CNT_W'(1);
        trip_inc     = (tripCount == {CNT_W{1'b1}}) ? tripCount : tripCount + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_NORMAL;
            run       <= '0;
            alarm     <= 1'b0;
            pending   <= 1'b0;
            causeLow  <= 1'b0;
            causeHigh <= 1'b0;
            tripCount <= '0;
            errFlag   <= 1'b0;
        end else begin
            if (malformed) begin
                errFlag <= 1'b1;
            end
            case (state)
                ST_NORMAL: begin
                    if (sample_ok && out_of_range) begin
                        if (TRIP_N == CNT_W'(1)) begin
                            state     <= ST_ALARM;
                            run       <= '0;
                            alarm     <= 1'b1;
                            causeLow  <= lowLess;
                            causeHigh <= highGreater;
                            tripCount <= trip_inc;
                        end else begin
                            state   <= ST_PENDING;
                            run     <= CNT_W'(1);
                            pending <= 1'b1;
                        end
                    end
                end
                ST_PENDING: begin
                    if (sample_ok) begin
                        if (!out_of_range) begin
                            state   <= ST_NORMAL;
                            run     <= '0;
                            pending <= 1'b0;
                        end else if (run_inc == TRIP_N) begin
                            state     <= ST_ALARM;
                            run       <= '0;
                            pending   <= 1'b0;
                            alarm     <= 1'b1;
                            causeLow  <= lowLess;
                            causeHigh <= highGreater;
                            tripCount <= trip_inc;
                        end else begin
                            run <= run_inc;
                        end
                    end
                end
                ST_ALARM: begin
                    // A sample arriving with the ack is deliberately not counted toward clearing.
                    if (ackPulse) begin
                        state <= ST_RECOVER;
                        run   <= '0;
                    end
                end
                ST_RECOVER: begin
                    if (sample_ok) begin
                        if (out_of_range) begin
                            run <= '0;
                        end else if (run_inc == CLEAR_N) begin
                            state     <= ST_NORMAL;
                            run       <= '0;
                            alarm     <= 1'b0;
                            causeLow  <= 1'b0;
                            causeHigh <= 1'b0;
                        end else begin
                            run <= run_inc;
                        end
                    end
                end
                default: begin
                    state <= ST_NORMAL;
                    run   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vital_alarm_controller.sv
// tb/tb_vital_alarm_controller.sv - directed self-checking bench for vital_alarm_controller
module tb_vital_alarm_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       sampleValid;
    logic       lowLess, lowEqual, lowGreater;
    logic       highLess, highEqual, highGreater;
    logic       ackPulse;
    logic       alarm, pending, causeLow, causeHigh, errFlag;
    logic [7:0] tripCount;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Flag triplets ordered {less, equal, greater}
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    vital_alarm_controller dut (
        .clock      (clock),
        .reset      (reset),
        .sampleValid(sampleValid),
        .lowLess    (lowLess),
        .lowEqual   (lowEqual),
        .lowGreater (lowGreater),
        .highLess   (highLess),
        .highEqual  (highEqual),
        .highGreater(highGreater),
        .ackPulse   (ackPulse),
        .alarm      (alarm),
        .pending    (pending),
        .causeLow   (causeLow),
        .causeHigh  (causeHigh),
        .tripCount  (tripCount),
        .errFlag    (errFlag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs at the falling edge; return #1 after the next rising edge.
    task automatic step(input logic v, input logic [2:0] lo, input logic [2:0] hi, input logic ack);
        @(negedge clock);
        sampleValid = v;
        {lowLess, lowEqual, lowGreater}    = lo;
        {highLess, highEqual, highGreater} = hi;
        ackPulse = ack;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, GT, LT, 1'b0);
    endtask

    task automatic in_range();
        step(1'b1, GT, LT, 1'b0);
    endtask

    task automatic hi_sample();
        step(1'b1, GT, GT, 1'b0);
    endtask

    task automatic lo_sample();
        step(1'b1, LT, LT, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alarm"},   alarm,     0);
        check({tag, "_pending"}, pending,   0);
        check({tag, "_cLow"},    causeLow,  0);
        check({tag, "_cHigh"},   causeHigh, 0);
        check({tag, "_trips"},   tripCount, 0);
        check({tag, "_err"},     errFlag,   0);
    endtask

    initial begin
        reset = 1'b1;
        sampleValid = 1'b0;
        {lowLess, lowEqual, lowGreater}    = GT;
        {highLess, highEqual, highGreater} = LT;
        ackPulse = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Ack while NORMAL must be ignored
        step(1'b0, GT, LT, 1'b1);
        check("ack_normal_alarm", alarm, 0);

        // Four high samples: pending after 1..3, alarm on the 4th
        for (int i = 1; i <= 3; i++) begin
            hi_sample();
            check($sformatf("hi%0d_pending", i), pending, 1);
            check($sformatf("hi%0d_alarm", i), alarm, 0);
            idle();
        end
        hi_sample();
        check("hi4_alarm", alarm, 1);
        check("hi4_pending", pending, 0);
        check("hi4_cHigh", causeHigh, 1);
        check("hi4_cLow", causeLow, 0);
        check("hi4_trips", tripCount, 1);

        // Ack, then in-range run broken by an out-of-range at sample 5
        step(1'b0, GT, LT, 1'b1);
        check("ack_alarm_held", alarm, 1);
        for (int i = 0; i < 4; i++) begin
            in_range();
            idle();
        end
        hi_sample();
        check("rec_oor_alarm", alarm, 1);
        for (int i = 1; i <= 7; i++) begin
            in_range();
            idle();
        end
        check("rec7_alarm", alarm, 1);
        check("rec7_cHigh", causeHigh, 1);
        in_range();
        check("rec8_alarm", alarm, 0);
        check("rec8_cHigh", causeHigh, 0);
        check("rec8_trips", tripCount, 1);

        // 3 low, 1 in-range, 3 low: never trips
        repeat (3) lo_sample();
        check("lo3_pending", pending, 1);
        in_range();
        check("lo_break_pending", pending, 0);
        repeat (3) lo_sample();
        check("lo3b_alarm", alarm, 0);
        check("lo3b_pending", pending, 1);
        in_range();
        check("lo_back_normal", pending, 0);

        // Malformed sample mid-run: flags error, does not advance the run
        repeat (2) lo_sample();
        step(1'b1, 3'b110, LT, 1'b0);
        check("bad_err", errFlag, 1);
        check("bad_pending", pending, 1);
        lo_sample();
        check("bad_no_trip", alarm, 0);
        lo_sample();
        check("lo_trip_alarm", alarm, 1);
        check("lo_trip_cLow", causeLow, 1);
        check("lo_trip_cHigh", causeHigh, 0);
        check("lo_trip_trips", tripCount, 2);

        // Ack coincident with a valid in-range sample: that sample is not counted
        step(1'b1, GT, LT, 1'b1);
        repeat (7) in_range();
        check("ackc_rec7_alarm", alarm, 1);
        in_range();
        check("ackc_rec8_alarm", alarm, 0);
        check("ackc_cLow", causeLow, 0);
        check("err_sticky", errFlag, 1);

        // Async reset inside RECOVER, between edges
        repeat (4) hi_sample();
        check("trip3_trips", tripCount, 3);
        step(1'b0, GT, LT, 1'b1);
        repeat (2) in_range();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async");
        @(negedge clock);
        reset = 1'b0;

        // 256 trips saturate at 255
        for (int t = 1; t <= 256; t++) begin
            repeat (4) hi_sample();
            if (t == 255) check("sat255_trips", tripCount, 255);
            step(1'b0, GT, LT, 1'b1);
            repeat (8) in_range();
        end
        check("sat256_trips", tripCount, 255);
        check("sat_alarm_clear", alarm, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
